// File: rtl/reg_file_sb.sv
// Register file with byte write enables and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   ReadReg1,
    input  logic [ADDR_W-1:0]   ReadReg2,
    output logic [DATA_W-1:0]   ReadData1,
    output logic [DATA_W-1:0]   ReadData2,
    output logic                Busy1,
    output logic                Busy2,
    input  logic                RegWre,
    input  logic [ADDR_W-1:0]   WriteReg,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic                IssueWre,
    input  logic [ADDR_W-1:0]   IssueReg,
    output logic [ADDR_W:0]     PendCnt
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [DATA_W-1:0] wdata_d;

    logic wr_zero;
    logic iss_zero;
    logic wr_ok;
    logic iss_ok;
    logic cnt_inc;
    logic cnt_dec;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign wr_zero  = (ZERO_REG != 0) && (WriteReg == '0);
    assign iss_zero = (ZERO_REG != 0) && (IssueReg == '0);
    assign wr_ok    = RegWre && !Reset && !wr_zero;
    assign iss_ok   = IssueWre && !Reset && !iss_zero;

    assign wdata_d = merge_bytes(mem_q[WriteReg], WriteData, ByteEn);

    // Count only real busy transitions; a same-register issue+write-back
    // keeps the bit set, so it never decrements.
    assign cnt_inc = iss_ok && !busy_q[IssueReg];
    assign cnt_dec = wr_ok && busy_q[WriteReg]
                     && !(iss_ok && (IssueReg == WriteReg));

    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[WriteReg] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[IssueReg] = 1'b1;
        end
    end

    assign cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_inc}
                         - {{ADDR_W{1'b0}}, cnt_dec};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[WriteReg] <= wdata_d;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [ADDR_W-1:0] ra   [2];
    logic [DATA_W-1:0] rdat [2];
    logic              rbsy [2];

    assign ra[0] = ReadReg1;
    assign ra[1] = ReadReg2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdat[p] = mem_q[ra[p]];
            rbsy[p] = busy_q[ra[p]];
            if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rdat[p] = '0;
                rbsy[p] = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (WriteReg == ra[p])) begin
                rdat[p] = wdata_d;
                if (!(iss_ok && (IssueReg == ra[p]))) begin
                    rbsy[p] = 1'b0;
                end
            end
`endif
        end
    end

    assign ReadData1 = rdat[0];
    assign ReadData2 = rdat[1];
    assign Busy1     = rbsy[0];
    assign Busy2     = rbsy[1];
    assign PendCnt   = cnt_q;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits (multiple of 8, at least 8).
REQ-002 SHALL provide parameter ADDR_W, default 5, register index width; depth is 2^ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-004 SHALL have port CLK  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports ReadReg1, ReadReg2  in  ADDR_W  read indices.
REQ-007 SHALL have ports ReadData1, ReadData2  out  DATA_W  read data.
REQ-008 SHALL have ports Busy1, Busy2  out  1  scoreboard busy bit of ReadReg1/ReadReg2.
REQ-009 SHALL have ports RegWre, WriteReg, WriteData  in  1/ADDR_W/DATA_W  write-back strobe, index and data.
REQ-010 SHALL have port ByteEn  in  DATA_W/8  byte write mask; bit i covers WriteData[8i+7:8i].
REQ-011 SHALL have ports IssueWre, IssueReg  in  1/ADDR_W  marks the destination of an issued instruction busy.
REQ-012 SHALL have port PendCnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-013 SHALL drive ReadDataN combinationally from the storage for ReadRegN, with no clock latency.
REQ-014 SHALL, on a CLK edge with RegWre=1, update only the bytes of register WriteReg whose ByteEn bit is 1; ByteEn=0 leaves the register unchanged.
REQ-015 SHALL, when ZERO_REG=1, read register 0 as all-zero and Busy 0, and ignore both writes and issues to register 0.
REQ-016 SHALL hold a busy bit per register: IssueWre=1 sets busy[IssueReg]; RegWre=1 clears busy[WriteReg], regardless of ByteEn.
REQ-017 SHALL, when IssueWre and RegWre target the same register in the same edge, leave busy set (the new issue wins) and still perform the data write.
REQ-018 SHALL update PendCnt each edge: +1 on a 0-to-1 busy transition, -1 on a 1-to-0 transition, and net 0 when both occur on different registers.
REQ-019 SHALL leave PendCnt unchanged when an issue targets a register that is already busy, or a write-back targets a register that is not busy.
REQ-020 SHALL keep PendCnt within 0..2^ADDR_W by construction, with no wrap-around.
REQ-021 SHALL drive BusyN combinationally as busy[ReadRegN].

Reset
REQ-022 SHALL, while Reset=1, immediately clear every register, every busy bit and PendCnt to 0, independent of CLK.
REQ-023 SHALL ignore RegWre and IssueWre while Reset=1; an operation in flight at reset assertion is discarded.
REQ-024 SHALL, after Reset deasserts, accept operations from the first rising CLK edge.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, make ReadDataN equal the stored value with the enabled WriteData bytes merged in whenever RegWre=1 and WriteReg==ReadRegN (excluding register 0 when ZERO_REG=1).
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, force BusyN to 0 in that same-cycle write-back case unless IssueWre also targets ReadRegN.
REQ-027 SHALL, without REGFILE_BYPASS_EN, show written data and the busy-bit clear only after the rising edge.

Verification
REQ-028 SHALL cover full-word write: Reset, then RegWre=1, WriteReg=5, WriteData=0x12345678, ByteEn=1111 -> ReadData1 (ReadReg1=5) = 0x12345678 after the edge.
REQ-029 SHALL cover byte-masked write: register 5 holds 0x12345678; write 0xAABBCCDD with ByteEn=0101 -> register 5 reads 0x12BB56DD.
REQ-030 SHALL cover register 0: write 0xFFFFFFFF to register 0 and issue register 0 -> ReadData=0, Busy=0, PendCnt=0.
REQ-031 SHALL cover the scoreboard: issue registers 3 then 4 -> PendCnt=2; then issue register 7 and write-back register 3 in one edge -> PendCnt=2, Busy of 3=0, Busy of 7=1.
REQ-032 SHALL cover issue/write-back collision: register 9 busy; IssueWre and RegWre both on register 9 with data 0x55 -> busy stays 1, register 9 reads 0x55, PendCnt unchanged.
REQ-033 SHALL cover reset mid-operation: Reset asserted between edges with PendCnt=3 and RegWre=1 -> outputs 0 immediately and no write lands; the bypass build additionally checks same-cycle forwarding of 0xCAFEBABE.
